// File: rtl/vga_timing_gen.sv
// Raster timing generator: free-running h/v counters, a registered pixel request
// one clock ahead of DE, and HSYNC/VSYNC/DE/frame_start aligned two clocks behind the counters.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 1024,
    parameter int unsigned H_FP     = 24,
    parameter int unsigned H_SYNC   = 136,
    parameter int unsigned H_BP     = 160,
    parameter int unsigned V_ACTIVE = 768,
    parameter int unsigned V_FP     = 3,
    parameter int unsigned V_SYNC   = 6,
    parameter int unsigned V_BP     = 29,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0
) (
    input  logic        pix_clk,
    input  logic        rst_n,
    input  logic        locked,
    output logic        pix_req,
    output logic [11:0] req_x,
    output logic [11:0] req_y,
    output logic        de,
    output logic        hsync,
    output logic        vsync,
    output logic        frame_start
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);

    // 13-bit bounds so that a full 4096-count raster still compares correctly
    localparam logic [12:0] H_ACT_END = 13'(H_ACTIVE);
    localparam logic [12:0] HS_BEG    = 13'(H_ACTIVE + H_FP);
    localparam logic [12:0] HS_END    = 13'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [12:0] V_ACT_END = 13'(V_ACTIVE);
    localparam logic [12:0] VS_BEG    = 13'(V_ACTIVE + V_FP);
    localparam logic [12:0] VS_END    = 13'(V_ACTIVE + V_FP + V_SYNC);

    logic [11:0] h_cnt;
    logic [11:0] v_cnt;
    logic [12:0] h_ext;
    logic [12:0] v_ext;
    logic        active;
    logic        hs_dec;
    logic        vs_dec;
    logic        hs_s1;
    logic        vs_s1;

    always_ff @(posedge pix_clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (!locked) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 12'd1;
        end else begin
            h_cnt <= h_cnt + 12'd1;
        end
    end

    // v_cnt only moves on the h_cnt wrap, so the vertical decode can only
    // change in the cycle the horizontal decode sees h_cnt == 0.
    always_comb begin
        h_ext  = {1'b0, h_cnt};
        v_ext  = {1'b0, v_cnt};
        active = (h_ext < H_ACT_END) && (v_ext < V_ACT_END);
        hs_dec = (h_ext >= HS_BEG) && (h_ext < HS_END);
        vs_dec = (v_ext >= VS_BEG) && (v_ext < VS_END);
    end

    always_ff @(posedge pix_clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_req <= 1'b0;
            req_x   <= '0;
            req_y   <= '0;
            hs_s1   <= 1'b0;
            vs_s1   <= 1'b0;
        end else if (!locked) begin
            pix_req <= 1'b0;
            req_x   <= '0;
            req_y   <= '0;
            hs_s1   <= 1'b0;
            vs_s1   <= 1'b0;
        end else begin
            pix_req <= active;
            req_x   <= active ? h_cnt : '0;
            req_y   <= active ? v_cnt : '0;
            hs_s1   <= hs_dec;
            vs_s1   <= vs_dec;
        end
    end

    always_ff @(posedge pix_clk or negedge rst_n) begin
        if (!rst_n) begin
            de          <= 1'b0;
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            frame_start <= 1'b0;
        end else if (!locked) begin
            de          <= 1'b0;
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            frame_start <= 1'b0;
        end else begin
            de          <= pix_req;
            hsync       <= hs_s1 ? HS_POL : ~HS_POL;
            vsync       <= vs_s1 ? VS_POL : ~VS_POL;
            frame_start <= pix_req && (req_x == '0) && (req_y == '0);
        end
    end

endmodule
